// File: rtl/div_seq_pkg.sv
// Shared state encoding and handshake constants for the DIV/DIVU sequencer.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration: shift in the next dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor holds between iterations, so WIDTH+1 bits capture the trial sign.
  always_comb begin
    shifted  = {rem, quo_msb};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage: stalls the pipe, then presents {HI, LO}.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               ready,
  output logic [2*WIDTH-1:0] result,
  output logic               stall_req
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             sign_a;
  logic             sign_b;
  logic             sgn_op;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;
  logic             last_iter;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo_msb  (quo[WIDTH-1]),
    .divisor  (divisor),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    abs_a     = (div_signed && opa[WIDTH-1]) ? -opa : opa;
    abs_b     = (div_signed && opb[WIDTH-1]) ? -opb : opb;
    quo_next  = {quo[WIDTH-2:0], step_q};
    fix_quo   = (sgn_op && (sign_a ^ sign_b)) ? -quo_next : quo_next;
    fix_rem   = (sgn_op && sign_a) ? -step_rem : step_rem;
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  // Gated by rst so the stall drops the moment reset asserts, even with div_start still high.
  assign stall_req = rst & div_start & ~ready & ~annul;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= DIV_IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      sgn_op  <= 1'b0;
      ready   <= DIV_RESULT_NOT_READY;
      result  <= '0;
    end else if (annul && state != DIV_IDLE) begin
      state <= DIV_IDLE;
      ready <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (div_start == DIV_START && !annul) begin
            if (opb == '0) begin
              state <= DIV_ZERO;
            end else begin
              state   <= DIV_BUSY;
              quo     <= abs_a;
              divisor <= abs_b;
              sign_a  <= opa[WIDTH-1];
              sign_b  <= opb[WIDTH-1];
              sgn_op  <= div_signed;
              cnt     <= '0;
              rem     <= '0;
            end
          end
        end
        DIV_ZERO: begin
          result <= '0;
          ready  <= DIV_RESULT_READY;
          state  <= DIV_DONE;
        end
        DIV_BUSY: begin
          rem <= step_rem;
          quo <= quo_next;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            state  <= DIV_DONE;
            ready  <= DIV_RESULT_READY;
            result <= {fix_rem, fix_quo};
          end
        end
        DIV_DONE: begin
          if (div_start == DIV_STOP) begin
            state <= DIV_IDLE;
            ready <= DIV_RESULT_NOT_READY;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver queues expected {HI,LO} and latency, monitor checks on ready.
module tb_div_seq;

  typedef struct {
    logic [63:0] res;
    int unsigned lat;
    int unsigned start;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic        annul;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        ready;
  logic [63:0] result;
  logic        stall_req;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  logic        ready_q  = 1'b0;

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_signed (div_signed),
    .annul      (annul),
    .opa        (opa),
    .opb        (opb),
    .ready      (ready),
    .result     (result),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: truncating division on 64-bit integers, low 32 bits kept (wraps MIN/-1).
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint la, lb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (ready && !ready_q) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got ready=1 result=%h expected no result", result);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, " result"}, result, mon_e.res);
        check({mon_e.name, " latency"}, 64'(cyc - mon_e.start + 1), 64'(mon_e.lat));
        check({mon_e.name, " stall_at_ready"}, 64'(stall_req), 64'd0);
      end
    end
    ready_q = ready;
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string name);
    exp_t        e;
    int unsigned n;
    int unsigned stalls;
    logic [63:0] held;
    @(negedge clk);
    opa        = a;
    opb        = b;
    div_signed = s;
    div_start  = 1'b1;
    e.res   = model(a, b, s);
    e.lat   = (b == 32'd0) ? 2 : 33;
    e.start = cyc + 1;
    e.name  = name;
    sb.push_back(e);
    n      = 0;
    stalls = 0;
    while (!ready && n < 200) begin
      #1;
      if (stall_req) stalls++;
      @(negedge clk);
      n++;
      if (n == 3) begin
        opa        = $urandom;
        opb        = $urandom;
        div_signed = ~s;
      end
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: got ready=0 after %0d cycles expected ready=1", name, n);
    end else begin
      check({name, " stall_cycles"}, 64'(stalls), 64'(e.lat));
      held = result;
      @(negedge clk);
      check({name, " done_hold_ready"}, 64'(ready), 64'd1);
      check({name, " done_hold_result"}, result, held);
      div_start = 1'b0;
      @(negedge clk);
      check({name, " ready_drop"}, 64'(ready), 64'd0);
    end
    div_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    int unsigned sel;

    rst        = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    annul      = 1'b0;
    opa        = '0;
    opb        = '0;
    #13;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, "div_m7_2");
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, "div_7_m2");
    run_div(32'h1234, 32'd0, 1'b0, "divu_by_zero");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "div_min_m1");

    // Annul part-way through a divide: no result may appear.
    @(negedge clk);
    opa        = 32'd1000;
    opb        = 32'd3;
    div_signed = 1'b0;
    div_start  = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul_stall_comb", 64'(stall_req), 64'd0);
    @(negedge clk);
    annul     = 1'b0;
    div_start = 1'b0;
    check("annul_ready", 64'(ready), 64'd0);
    check("annul_stall", 64'(stall_req), 64'd0);
    repeat (40) @(negedge clk);
    check("annul_no_result", 64'(ready), 64'd0);
    run_div(32'd9, 32'd4, 1'b0, "divu_9_4_after_annul");

    // Asynchronous reset between edges while busy.
    @(negedge clk);
    opa        = 32'd1000;
    opb        = 32'd7;
    div_signed = 1'b0;
    div_start  = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_ready", 64'(ready), 64'd0);
    check("midreset_result", result, 64'd0);
    check("midreset_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    div_start = 1'b0;
    rst       = 1'b1;
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, "divu_max_1");

    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      b   = $urandom;
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 5);
      case (sel)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF;
        3: a = 32'h80000000;
        default: ;
      endcase
      run_div(a, b, s, $sformatf("rand%0d", i));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
